// File: rtl/phase_sync_rx.sv
// Clocked receiver for the dual-rail PH0/PH1/PH2 phase ring.
// Synchronises each phase token, returns a four-phase acknowledge per phase,
// checks phase order, counts completed rounds and watches for a stalled ring.
//
// Handshake (per phase i): the ring drives a data codeword (01/10) on ph_i,
// this block raises ack_ph_i one cycle after the synchronised codeword is
// seen (only while ack_en=1), the ring returns ph_i to null (00), and
// ack_ph_i falls one cycle after the synchronised null is seen, regardless of
// ack_en. The codeword 11 is never acknowledged.
module phase_sync_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT     = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       ph0,
  input  logic [1:0]       ph1,
  input  logic [1:0]       ph2,
  input  logic             ack_en,
  input  logic             clr,
  output logic             ack_ph0,
  output logic             ack_ph1,
  output logic             ack_ph2,
  output logic             cap_valid,
  output logic [1:0]       cap_idx,
  output logic             cap_bit,
  output logic [CNT_W-1:0] round_cnt,
  output logic             err_order,
  output logic             err_illegal,
  output logic             stall,
  // {expected index[1:0], channel state PH2, PH1, PH0} for trace and checkers
  output logic [4:0]       dbg_state
);

  localparam logic [0:0] WAIT_DATA = 1'b0;
  localparam logic [0:0] ACKED     = 1'b1;

  localparam int TO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT - 1);

  // Raw inputs gathered into an array so the channels are handled uniformly
  logic [1:0] ph_in [3];
  assign ph_in[0] = ph0;
  assign ph_in[1] = ph1;
  assign ph_in[2] = ph2;

  logic [1:0] sync_q [3][SYNC_STAGES];
  logic [1:0] s_ph   [3];

  logic [0:0] state_q [3];
  logic [0:0] state_d [3];
  logic [2:0] cap;
  logic [2:0] illegal;

  logic [1:0]       exp_q, exp_d;
  logic             cap_valid_q;
  logic [1:0]       cap_idx_q, cap_idx_d;
  logic             cap_bit_q, cap_bit_d;
  logic [CNT_W-1:0] round_q, round_d;
  logic             err_order_q, err_order_d;
  logic             err_illegal_q, err_illegal_d;
  logic             stall_q, stall_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;

  logic       any_cap;
  logic       multi_cap;
  logic [1:0] hi_idx;
  logic       hi_bit;
  logic       in_order;
  logic       round_inc;

  // Next phase index in the ring, wrapping PH2 back to PH0
  function automatic logic [1:0] next_idx(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  // Input synchroniser chains, one per phase, cleared to null in reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 3; c++) begin
        for (int s = 0; s < SYNC_STAGES; s++) begin
          sync_q[c][s] <= 2'b00;
        end
      end
    end else begin
      for (int c = 0; c < 3; c++) begin
        sync_q[c][0] <= ph_in[c];
        for (int s = 1; s < SYNC_STAGES; s++) begin
          sync_q[c][s] <= sync_q[c][s-1];
        end
      end
    end
  end

  always_comb begin
    for (int c = 0; c < 3; c++) begin
      s_ph[c] = sync_q[c][SYNC_STAGES-1];
    end
  end

  // Per-channel handshake FSM: capture on data (gated by ack_en), release on null
  always_comb begin
    for (int c = 0; c < 3; c++) begin
      state_d[c] = state_q[c];
      cap[c]     = 1'b0;
      illegal[c] = (s_ph[c] == 2'b11);
      if (state_q[c] == WAIT_DATA) begin
        if ((s_ph[c] == 2'b01 || s_ph[c] == 2'b10) && ack_en) begin
          cap[c]     = 1'b1;
          state_d[c] = ACKED;
        end
      end else begin
        if (s_ph[c] == 2'b00) begin
          state_d[c] = WAIT_DATA;
        end
      end
    end
  end

  // Channel state registers; the ack outputs are these states directly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 3; c++) begin
        state_q[c] <= WAIT_DATA;
      end
    end else begin
      for (int c = 0; c < 3; c++) begin
        state_q[c] <= state_d[c];
      end
    end
  end

  // Capture decode: highest-index winner, order check and round detection
  always_comb begin
    any_cap   = |cap;
    multi_cap = (cap[0] & cap[1]) | (cap[0] & cap[2]) | (cap[1] & cap[2]);
    hi_idx    = 2'd0;
    hi_bit    = s_ph[0][1];
    if (cap[2]) begin
      hi_idx = 2'd2;
      hi_bit = s_ph[2][1];
    end else if (cap[1]) begin
      hi_idx = 2'd1;
      hi_bit = s_ph[1][1];
    end
    in_order  = any_cap && !multi_cap && (hi_idx == exp_q);
    round_inc = in_order && (hi_idx == 2'd2);
    // In order, hi_idx equals exp, so both cases advance past hi_idx
    exp_d     = any_cap ? next_idx(hi_idx) : exp_q;
    cap_idx_d = any_cap ? hi_idx : cap_idx_q;
    cap_bit_d = any_cap ? hi_bit : cap_bit_q;
  end

  // Sticky flags, round counter and idle timer; a set beats clr
  always_comb begin
    round_d = clr ? '0 : round_q;
    if (round_inc) begin
      round_d = round_d + 1'b1;
    end

    err_order_d = err_order_q & ~clr;
    if (any_cap && !in_order) begin
      err_order_d = 1'b1;
    end

    err_illegal_d = err_illegal_q & ~clr;
    if (|illegal) begin
      err_illegal_d = 1'b1;
    end

    if (any_cap || clr) begin
      to_cnt_d = '0;
    end else if (to_cnt_q == TO_MAX) begin
      to_cnt_d = to_cnt_q;
    end else begin
      to_cnt_d = to_cnt_q + 1'b1;
    end

    stall_d = stall_q & ~clr;
    if (to_cnt_d == TO_MAX) begin
      stall_d = 1'b1;
    end
  end

  // Capture report, order tracking and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q         <= 2'd0;
      cap_valid_q   <= 1'b0;
      cap_idx_q     <= 2'd0;
      cap_bit_q     <= 1'b0;
      round_q       <= '0;
      err_order_q   <= 1'b0;
      err_illegal_q <= 1'b0;
      stall_q       <= 1'b0;
      to_cnt_q      <= '0;
    end else begin
      exp_q         <= exp_d;
      cap_valid_q   <= any_cap;
      cap_idx_q     <= cap_idx_d;
      cap_bit_q     <= cap_bit_d;
      round_q       <= round_d;
      err_order_q   <= err_order_d;
      err_illegal_q <= err_illegal_d;
      stall_q       <= stall_d;
      to_cnt_q      <= to_cnt_d;
    end
  end

  assign ack_ph0     = (state_q[0] == ACKED);
  assign ack_ph1     = (state_q[1] == ACKED);
  assign ack_ph2     = (state_q[2] == ACKED);
  assign cap_valid   = cap_valid_q;
  assign cap_idx     = cap_idx_q;
  assign cap_bit     = cap_bit_q;
  assign round_cnt   = round_q;
  assign err_order   = err_order_q;
  assign err_illegal = err_illegal_q;
  assign stall       = stall_q;
  assign dbg_state   = {exp_q, state_q[2], state_q[1], state_q[0]};

endmodule

// File: tb/tb_phase_sync_rx.sv
// Directed bench for phase_sync_rx: latency, rounds, back-pressure, order
// errors, illegal codewords, stall timer, counter wrap and simultaneous tokens.
module tb_phase_sync_rx;

  localparam int SYNC_STAGES = 2;
  localparam int CNT_W       = 2;
  localparam int TIMEOUT     = 16;

  logic             clk;
  logic             rst_n;
  logic [1:0]       ph0, ph1, ph2;
  logic             ack_en;
  logic             clr;
  logic             ack_ph0, ack_ph1, ack_ph2;
  logic             cap_valid;
  logic [1:0]       cap_idx;
  logic             cap_bit;
  logic [CNT_W-1:0] round_cnt;
  logic             err_order;
  logic             err_illegal;
  logic             stall;
  logic [4:0]       dbg_state;

  int n_tests;
  int n_fail;
  int cap_cnt;
  int snap;

  phase_sync_rx #(
    .SYNC_STAGES(SYNC_STAGES),
    .CNT_W      (CNT_W),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ph0        (ph0),
    .ph1        (ph1),
    .ph2        (ph2),
    .ack_en     (ack_en),
    .clr        (clr),
    .ack_ph0    (ack_ph0),
    .ack_ph1    (ack_ph1),
    .ack_ph2    (ack_ph2),
    .cap_valid  (cap_valid),
    .cap_idx    (cap_idx),
    .cap_bit    (cap_bit),
    .round_cnt  (round_cnt),
    .err_order  (err_order),
    .err_illegal(err_illegal),
    .stall      (stall),
    .dbg_state  (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count capture pulses as seen at each rising edge
  initial cap_cnt = 0;
  always @(posedge clk) begin
    if (cap_valid) cap_cnt <= cap_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n cycles, landing 1 time unit after the rising edge
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_ph(input int ch, input logic [1:0] v);
    case (ch)
      0: ph0 = v;
      1: ph1 = v;
      default: ph2 = v;
    endcase
  endtask

  function automatic logic get_ack(input int ch);
    case (ch)
      0: return ack_ph0;
      1: return ack_ph1;
      default: return ack_ph2;
    endcase
  endfunction

  // Full four-phase transfer on one channel with bounded waits
  task automatic send(input int ch, input logic b);
    set_ph(ch, b ? 2'b10 : 2'b01);
    for (int k = 0; k < 20; k++) begin
      tick(1);
      if (get_ack(ch)) break;
    end
    check($sformatf("send_ack_rise_ch%0d", ch), 32'(get_ack(ch)), 1);
    set_ph(ch, 2'b00);
    for (int k = 0; k < 20; k++) begin
      tick(1);
      if (!get_ack(ch)) break;
    end
    check($sformatf("send_ack_fall_ch%0d", ch), 32'(get_ack(ch)), 0);
  endtask

  task automatic do_reset();
    ph0 = 2'b00; ph1 = 2'b00; ph2 = 2'b00;
    clr = 1'b0; ack_en = 1'b1;
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    ph0 = 2'b00; ph1 = 2'b00; ph2 = 2'b00;
    ack_en = 1'b1; clr = 1'b0; rst_n = 1'b0;
    tick(2);

    // Reset state
    check("rst_acks", 32'({ack_ph2, ack_ph1, ack_ph0}), 0);
    check("rst_cap_valid", 32'(cap_valid), 0);
    check("rst_cap_idx", 32'(cap_idx), 0);
    check("rst_cap_bit", 32'(cap_bit), 0);
    check("rst_round", 32'(round_cnt), 0);
    check("rst_errs", 32'({err_order, err_illegal, stall}), 0);
    check("rst_dbg", 32'(dbg_state), 0);

    // Stall timer: idle from reset release, flags after 15 edges
    rst_n = 1'b1;
    tick(14);
    check("stall_before", 32'(stall), 0);
    tick(1);
    check("stall_set", 32'(stall), 1);
    tick(5);
    check("stall_sticky", 32'(stall), 1);
    pulse_clr();
    check("stall_clr", 32'(stall), 0);

    // Ack latency: rises SYNC_STAGES+1 edges after the input change
    ph0 = 2'b01;
    tick(2);
    check("lat_ack_early", 32'(ack_ph0), 0);
    tick(1);
    check("lat_ack_rise", 32'(ack_ph0), 1);
    check("lat_cap_valid", 32'(cap_valid), 1);
    check("lat_cap_idx", 32'(cap_idx), 0);
    check("lat_cap_bit", 32'(cap_bit), 0);
    tick(1);
    check("lat_cap_pulse_end", 32'(cap_valid), 0);
    ph0 = 2'b00;
    tick(2);
    check("lat_ack_hold", 32'(ack_ph0), 1);
    tick(1);
    check("lat_ack_fall", 32'(ack_ph0), 0);

    // Three clean rounds, then a fourth wraps the 2-bit counter
    do_reset();
    snap = cap_cnt;
    for (int r = 0; r < 3; r++) begin
      send(0, 1'b1);
      send(1, 1'b0);
      send(2, 1'b1);
    end
    check("rounds_cnt", 32'(round_cnt), 3);
    check("rounds_err_order", 32'(err_order), 0);
    check("rounds_pulses", 32'(cap_cnt - snap), 9);
    check("rounds_cap_idx", 32'(cap_idx), 2);
    check("rounds_cap_bit", 32'(cap_bit), 1);
    send(0, 1'b0);
    send(1, 1'b1);
    send(2, 1'b0);
    check("wrap_cnt", 32'(round_cnt), 0);
    check("wrap_err_order", 32'(err_order), 0);
    check("wrap_cap_bit", 32'(cap_bit), 0);

    // Back-pressure: no capture while ack_en=0, ack one edge after release
    ack_en = 1'b0;
    ph1 = 2'b10;
    snap = cap_cnt;
    tick(20);
    check("bp_ack_held", 32'(ack_ph1), 0);
    check("bp_no_capture", 32'(cap_cnt - snap), 0);
    ack_en = 1'b1;
    tick(1);
    check("bp_ack_rise", 32'(ack_ph1), 1);
    check("bp_cap_idx", 32'(cap_idx), 1);
    check("bp_err_order", 32'(err_order), 1);
    ph1 = 2'b00;
    tick(3);
    check("bp_ack_fall", 32'(ack_ph1), 0);

    // Out-of-order start, resync, clean round, clr
    do_reset();
    send(2, 1'b0);
    check("ooo_err_order", 32'(err_order), 1);
    check("ooo_exp", 32'(dbg_state[4:3]), 0);
    check("ooo_round", 32'(round_cnt), 0);
    send(0, 1'b1);
    send(1, 1'b1);
    send(2, 1'b1);
    check("ooo_round_after", 32'(round_cnt), 1);
    pulse_clr();
    check("ooo_clr_err", 32'(err_order), 0);
    check("ooo_clr_round", 32'(round_cnt), 0);

    // Illegal codeword: flagged, never acknowledged or captured
    snap = cap_cnt;
    ph1 = 2'b11;
    tick(3);
    check("ill_flag", 32'(err_illegal), 1);
    check("ill_no_ack", 32'(ack_ph1), 0);
    tick(4);
    check("ill_no_capture", 32'(cap_cnt - snap), 0);
    check("ill_exp_kept", 32'(dbg_state[4:3]), 0);
    ph1 = 2'b00;
    tick(3);
    check("ill_sticky", 32'(err_illegal), 1);
    pulse_clr();
    check("ill_clr", 32'(err_illegal), 0);

    // Simultaneous PH0/PH1 tokens
    do_reset();
    ph0 = 2'b01;
    ph1 = 2'b10;
    tick(3);
    check("sim_acks", 32'({ack_ph1, ack_ph0}), 3);
    check("sim_cap_valid", 32'(cap_valid), 1);
    check("sim_cap_idx", 32'(cap_idx), 1);
    check("sim_cap_bit", 32'(cap_bit), 1);
    check("sim_err_order", 32'(err_order), 1);
    check("sim_round", 32'(round_cnt), 0);
    check("sim_exp", 32'(dbg_state[4:3]), 2);
    ph0 = 2'b00;
    ph1 = 2'b00;
    tick(3);
    check("sim_acks_fall", 32'({ack_ph1, ack_ph0}), 0);
    pulse_clr();
    send(2, 1'b1);
    check("sim_next_round", 32'(round_cnt), 1);
    check("sim_next_err", 32'(err_order), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/phase_sync_rx.md
Name: phase_sync_rx

Overview:
- Clocked receiving end of the dual-rail PH0/PH1/PH2 phase ring.
- Synchronises the three 2-bit phase tokens into the clock domain and returns a four-phase acknowledge per phase, so a synchronous peripheral can take part in the ring as an ack source.
- Also checks phase order and counts completed rounds.
- Used for debug/trace and as a bridge for synchronous test logic.

Parameters:
- SYNC_STAGES, 2, flops in each input synchroniser chain (minimum 2).
- CNT_W, 16, width of round_cnt.
- TIMEOUT, 1024, cycles without any token capture before stall is flagged (minimum 2).

Ports:
- clk  input  1  single clock.
- rst_n  input  1  asynchronous, active-low reset.
- ph0  input  2  dual-rail phase token PH0.
- ph1  input  2  dual-rail phase token PH1.
- ph2  input  2  dual-rail phase token PH2.
- ack_en  input  1  consumer ready; when 0, no new acknowledge is raised (back-pressure).
- clr  input  1  synchronous clear of sticky flags and round_cnt.
- ack_ph0  output  1  acknowledge returned for PH0.
- ack_ph1  output  1  acknowledge returned for PH1.
- ack_ph2  output  1  acknowledge returned for PH2.
- cap_valid  output  1  one-cycle pulse when a token is captured.
- cap_idx  output  2  phase index of the last captured token (0..2).
- cap_bit  output  1  data value of the last captured token.
- round_cnt  output  CNT_W  number of completed PH0->PH1->PH2 rounds.
- err_order  output  1  sticky; out-of-order phase seen.
- err_illegal  output  1  sticky; 2'b11 codeword seen.
- stall  output  1  sticky; TIMEOUT exceeded.

Behaviour:
- Dual-rail encoding:
  - 2'b00 = null (spacer).
  - 2'b01 = logic 0.
  - 2'b10 = logic 1.
  - 2'b11 = illegal.
- Each ph input passes through its own SYNC_STAGES-flop chain. All decisions use the synchronised value (s_phi).
- Reset (rst_n=0, asynchronous):
  - All synchroniser flops are cleared to 2'b00.
  - All acks, cap_valid, cap_idx, cap_bit, round_cnt, err_order, err_illegal and stall are 0.
  - Every channel FSM is in WAIT_DATA.
  - Expected index exp = 0.
  - The timeout counter is 0.
- Per-channel FSM, states WAIT_DATA and ACKED:
  - WAIT_DATA, s_phi is 01 or 10, and ack_en=1: capture the token and go to ACKED. ack_phi goes 1 on the next clock edge, so the ack rises 1 cycle after the synchronised data.
  - WAIT_DATA with ack_en=0: hold state; ack stays 0 and the token is not captured.
  - ACKED, s_phi=00: go to WAIT_DATA; ack_phi goes 0 on the next edge. ack_en does not gate the falling edge of the ack.
  - ACKED with s_phi non-null: hold.
  - s_phi=11 in any state: set err_illegal; no state change and no capture.
- Capture event:
  - cap_valid pulses for exactly 1 cycle.
  - cap_idx=i and cap_bit=s_phi[1] are registered and held until the next capture.
- Order check on a single capture at channel i:
  - i==exp: exp=(exp+1) mod 3. If i==2, round_cnt increments, wrapping from 2^CNT_W-1 to 0.
  - i!=exp: set err_order and resynchronise with exp=(i+1) mod 3. round_cnt is not incremented on that capture.
- Simultaneous captures on two or more channels in one cycle:
  - All of them are acknowledged.
  - err_order is set.
  - cap_idx and cap_bit report the highest index.
  - exp=(highest i + 1) mod 3.
  - round_cnt is unchanged.
- Timeout:
  - The counter is cleared on any capture and on clr, and increments otherwise.
  - When the count reaches TIMEOUT-1, stall is set and the counter saturates.
- clr=1 clears err_order, err_illegal, stall, round_cnt and the timeout counter on the next edge. It does not affect the FSMs, acks, exp or cap_* outputs.
- If clr and a set condition occur in the same cycle, the set wins. A round_cnt increment in the same cycle as clr yields 1.
- Reset mid-handshake drops all acks immediately (asynchronously). The ring must be held in reset together with this block.

Test Plan:
- Reset, then drive ph0=01 (ph1/ph2 null) with ack_en=1 -> ack_ph0=1 exactly SYNC_STAGES+1 cycles after the input change; cap_valid pulses once with cap_idx=0, cap_bit=0. Then set ph0=00 -> ack_ph0 drops SYNC_STAGES+1 cycles later.
- Run 3 full rounds of PH0(10), PH1(01), PH2(10), each returned to null -> round_cnt=3; err_order=0; 9 cap_valid pulses; last cap_idx=2, cap_bit=1.
- Hold ack_en=0 with ph1=10 for 20 cycles -> ack_ph1 stays 0 and no cap_valid. Release ack_en -> ack_ph1 rises on the next edge after release.
- After reset, present ph2=01 first -> err_order=1, exp resyncs to 0, round_cnt=0. Then run a clean round -> round_cnt=1. Pulse clr -> err_order=0, round_cnt=0.
- Drive ph1=11 -> err_illegal=1 with no ack and no capture. With TIMEOUT=16 and no activity after reset -> stall=1 at cycle 15 and stays set until clr.
- With CNT_W=2, run 4 rounds -> round_cnt wraps to 0. Present ph0 and ph1 valid in the same cycle -> both acks raised, err_order=1, cap_idx=1.
